// File: rtl/pipe_chain_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_chain_if
//  Purpose  : Valid/ready handshake bundle for pipe_chain. The chain itself
//             uses the slave view (consumes input, produces output); the
//             surrounding logic uses the master view.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_chain_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data
    );
endinterface
`default_nettype wire

// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_chain
//  Purpose  : Elastic chain of DEPTH pipeline registers with valid/ready
//             backpressure, bubble collapsing, per-stage flush and a
//             registered occupancy count.
//  Options  : PIPE_CHAIN_PERF_EN - enables the saturating stall/kill
//             counters; when undefined both outputs are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic            clock,
    input  wire logic            rst,
    pipe_chain_if.slave          bus,
    input  wire logic [DEPTH-1:0] i_flush,
    output logic [CW-1:0]        o_occupancy,
    output logic [31:0]          o_stall_cnt,
    output logic [31:0]          o_kill_cnt
);

    // Stage registers
    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [CW-1:0]    r_occupancy;

    // Combinational helpers
    logic [DEPTH-1:0] w_ready;
    logic             w_ready_acc;
    logic [DEPTH-1:0] w_src_valid;
    logic [WIDTH-1:0] w_src_data [DEPTH];
    logic [DEPTH-1:0] w_valid_keep;
    logic [DEPTH-1:0] w_valid_nxt;
    logic [CW-1:0]    w_occ_nxt;

    // Stage 0 is fed from the upstream port, every later stage from its
    // predecessor.
    assign w_src_valid[0] = bus.in_valid;
    assign w_src_data[0]  = bus.in_data;

    generate
        for (genvar g = 1; g < DEPTH; g++) begin : g_src
            assign w_src_valid[g] = r_valid[g-1];
            assign w_src_data[g]  = r_data[g-1];
        end
    endgenerate

    // Ready ripples from the output backwards: a stage can take new data if
    // it is empty or anything downstream of it can move. Written as an
    // accumulating OR so the vector never reads its own bits.
    always_comb begin
        w_ready     = '0;
        w_ready_acc = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_ready_acc = w_ready_acc || !r_valid[i];
            w_ready[i]  = w_ready_acc;
        end
    end

    // Next-state valid vector: the value each stage would take without
    // flush, then flush forces a bubble on top of it.
    always_comb begin
        w_valid_keep = '0;
        w_valid_nxt  = '0;
        w_occ_nxt    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_keep[i] = w_ready[i] ? w_src_valid[i] : r_valid[i];
            w_valid_nxt[i]  = w_valid_keep[i] && !i_flush[i];
            w_occ_nxt       = w_occ_nxt + CW'(w_valid_nxt[i]);
        end
    end

    // Valid bits and occupancy; cleared asynchronously on reset.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_valid     <= '0;
            r_occupancy <= '0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_occupancy <= w_occ_nxt;
        end
    end

    // Payload registers load whenever their stage is ready; a flushed stage
    // may keep stale data since its valid bit is low.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ready[i]) begin
                    r_data[i] <= w_src_data[i];
                end
            end
        end
    end

    assign bus.in_ready  = w_ready[0];
    assign bus.out_valid = r_valid[DEPTH-1];
    assign bus.out_data  = r_data[DEPTH-1];
    assign o_occupancy   = r_occupancy;

`ifdef PIPE_CHAIN_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_kill_cnt;
    logic [CW-1:0] w_kill_num;
    logic [32:0]   w_kill_sum;

    // Number of entries destroyed by flush this cycle.
    always_comb begin
        w_kill_num = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill_num = w_kill_num + CW'(w_valid_keep[i] && i_flush[i]);
        end
        w_kill_sum = {1'b0, r_kill_cnt} + 33'(w_kill_num);
    end

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_kill_cnt  <= '0;
        end else begin
            if (r_valid[DEPTH-1] && !bus.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            r_kill_cnt <= w_kill_sum[32] ? 32'hFFFF_FFFF : w_kill_sum[31:0];
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_kill_cnt  = r_kill_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_kill_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_chain
//  Purpose  : Scoreboard bench for pipe_chain (WIDTH=32, DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_chain;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef PIPE_CHAIN_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clock;
    logic             rst;
    logic [DEPTH-1:0] flush;
    logic [CW-1:0]    occupancy;
    logic [31:0]      stall_cnt;
    logic [31:0]      kill_cnt;

    pipe_chain_if #(.WIDTH(WIDTH)) bus ();

    pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clock       (clock),
        .rst         (rst),
        .bus         (bus.slave),
        .i_flush     (flush),
        .o_occupancy (occupancy),
        .o_stall_cnt (stall_cnt),
        .o_kill_cnt  (kill_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Output side pops before the input side pushes; inputs are stable at
    // the falling edge, so what is seen here is what the next rising edge
    // transfers.
    always @(negedge clock) begin
        if (rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    check_eq("out_data", bus.out_data, sb.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready && !flush[0]) begin
                sb.push_back(bus.in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
            tick();
            n++;
        end
        check_eq("drain_left", 32'(sb.size()), 32'd0);
        check_eq("drain_occ", 32'(occupancy), 32'd0);
    endtask

    task automatic push(input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int edges;
        rst           = 1'b0;
        flush         = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data", bus.out_data, 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_occ", 32'(occupancy), 32'd0);
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        #1;

        // Hold three entries, then assert reset mid-cycle.
        push(32'h0000_00C1);
        push(32'h0000_00C2);
        push(32'h0000_00C3);
        check_eq("hold3_occ", 32'(occupancy), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("arst_occ", 32'(occupancy), 32'd0);
        check_eq("arst_stall", stall_cnt, 32'd0);
        check_eq("arst_kill", kill_cnt, 32'd0);
        check_eq("arst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        @(negedge clock);
        #1;
        rst = 1'b1;
        @(posedge clock);
        #1;

        // Latency: accepted at edge 1, visible after edge 4.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA5A5_0001;
        edges = 0;
        while (edges < 20) begin
            tick();
            edges++;
            if (edges == 1) bus.in_valid = 1'b0;
            if (bus.out_valid) break;
        end
        check_eq("latency", edges, 32'd4);
        check_eq("lat_data", bus.out_data, 32'hA5A5_0001);
        drain();

        // Streaming 0x10..0x17 with out_ready high.
        bus.out_ready = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h10 + 32'(e - 1);
            tick();
            if (e >= 4) begin
                check_eq("stream_occ", 32'(occupancy), 32'd4);
                check_eq("stream_head", bus.out_data, 32'h10 + 32'(e - 4));
            end
        end
        drain();

        // Backpressure and bubble collapsing.
        bus.out_ready = 1'b0;
        push(32'h1);
        tick();
        tick();
        push(32'h2);
        tick();
        tick();
        tick();
        check_eq("bp_occ2", 32'(occupancy), 32'd2);
        check_eq("bp_head", bus.out_data, 32'h1);
        check_eq("bp_in_ready2", 32'(bus.in_ready), 32'd1);
        push(32'h3);
        push(32'h4);
        check_eq("bp_occ4", 32'(occupancy), 32'd4);
        check_eq("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("bp_release_head", bus.out_data, 32'h1);
        drain();

        // Flush stages 0 and 1 of a full chain.
        bus.out_ready = 1'b0;
        push(32'h1);
        push(32'h2);
        push(32'h3);
        push(32'h4);
        check_eq("fl_occ_full", 32'(occupancy), 32'd4);
        flush = 4'b0011;
        tick();
        flush = '0;
        void'(sb.pop_back());
        void'(sb.pop_back());
        check_eq("fl_occ", 32'(occupancy), 32'd2);
        check_eq("fl_head", bus.out_data, 32'h1);
        check_eq("fl_kill", kill_cnt, PERF ? 32'd2 : 32'd0);
        drain();

        // Flush coinciding with load on an empty chain.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hBEEF;
        flush        = 4'b0001;
        #1;
        check_eq("fll_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        flush        = '0;
        check_eq("fll_occ", 32'(occupancy), 32'd0);
        check_eq("fll_kill", kill_cnt, PERF ? 32'd3 : 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("fll_out_valid", 32'(bus.out_valid), 32'd0);

        // Stall counter from a fresh reset.
        #2;
        rst = 1'b0;
        #1;
        check_eq("st_rst_stall", stall_cnt, 32'd0);
        @(negedge clock);
        #1;
        rst = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        push(32'h5A);
        edges = 0;
        while (!bus.out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check_eq("st_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("st_stall0", stall_cnt, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check_eq("st_stall10", stall_cnt, PERF ? 32'd10 : 32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised elastic pipeline-register chain: DEPTH stages of WIDTH-bit payload, each with its own valid bit.
- Replaces the fixed per-boundary flip-flops (PC→IF/ID→ID/EX→EX/MEM→MEM/WB) with one reusable block.
- Adds valid/ready backpressure, bubble collapsing, a per-stage flush mask and an occupancy count.
- Sits between pipeline stages in the CPU top; the core instantiates one chain per payload bundle.

Parameters:
- WIDTH, 32, payload bits per stage.
- DEPTH, 4, number of register stages (≥1).
- CW, $clog2(DEPTH+1), width of the occupancy output (derived; do not override).

Ports:
- clock  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset; low forces reset state immediately.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  chain accepts in_data this cycle.
- in_data  input  WIDTH  payload entering stage 0.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  WIDTH  payload of stage DEPTH-1.
- flush  input  DEPTH  bit i: stage i loads a bubble at the next edge.
- occupancy  output  CW  number of valid stages (registered).
- stall_cnt  output  32  cycles with out_valid=1 and out_ready=0 (see Optional Feature).
- kill_cnt  output  32  valid entries discarded by flush (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): all valid bits=0, all data=0, occupancy=0, stall_cnt=0, kill_cnt=0. Hence out_valid=0, out_data=0, in_ready=1.
- Notation: v[i]/d[i] are stage i's registers. The source of stage 0 is in_valid/in_data; the source of stage i>0 is v[i-1]/d[i-1]. ready[DEPTH]=out_ready.
- ready[i] = !v[i] || ready[i+1] (combinational; bubble collapsing). in_ready = ready[0]. ready never depends on flush, so there is no combinational loop.
- Per edge, for each stage i:
  - If ready[i]: v[i] <= src_valid && !flush[i]; d[i] <= src_data.
  - Else: v[i] <= v[i] && !flush[i]; d[i] holds.
- Flush has priority over load and hold. Data registers may retain stale payload under v=0; out_data is don't-care when out_valid=0.
- Transfer on the input side: in_valid && in_ready. Transfer on the output side: out_valid && out_ready.
- An input handshake that coincides with flush[0]=1 counts as accepted and is discarded.
- Latency: an entry accepted into an empty chain at edge k shows out_valid=1 after edge k+DEPTH-1 (DEPTH cycles through registers). Throughput is 1 entry/cycle with out_ready held high.
- Full: all v=1 and out_ready=0 gives in_ready=0; contents hold. Full with out_ready=1: every stage shifts, and in_ready=1 in the same cycle.
- Entry order is preserved; no entry is duplicated or reordered.
- occupancy <= popcount of the next-state valid vector (equals the popcount of v after the edge). Range 0..DEPTH; no wrap.
- Reset assertion mid-operation discards all entries asynchronously. The first edge after release behaves as from the empty state.
- DEPTH=1: single register with ready = !v || out_ready.

Optional Feature:
- Macro PIPE_CHAIN_PERF_EN.
- Defined:
  - stall_cnt +1 each edge with out_valid && !out_ready.
  - kill_cnt + (number of stages i where flush[i] && the value v[i] would otherwise have taken is 1).
  - Both saturate at 32'hFFFF_FFFF and clear only on reset.
- Undefined: stall_cnt and kill_cnt are tied to 0; no counter flops are synthesised. Port list is unchanged.

Test Plan:
- Reset/idle: rst=0 mid-cycle with 3 entries held → out_valid, occupancy and both counters 0 immediately; in_ready=1. After release, push 32'hA5A5_0001 → out_valid at 4th edge.
- Streaming: WIDTH=32, DEPTH=4, out_ready=1, push 0x10..0x17 back-to-back → outputs 0x10..0x17 in order, one per cycle, starting at the 4th edge; occupancy settles at 4.
- Backpressure/collapse: out_ready=0, push 0x1,0x2 with a 2-cycle gap between them → both compact to stages 3,2, occupancy=2. Fill to 4 → in_ready=0. Raise out_ready → 0x1 first, in_ready=1 in the same cycle.
- Flush: chain full with 0x1..0x4 (0x4 at stage 0), out_ready=0, flush=4'b0011 for one cycle → occupancy=2; outputs 0x1 then 0x2; kill_cnt=2 (PIPE_CHAIN_PERF_EN).
- Flush+load same cycle: empty chain, in_valid=1, in_data=0xBEEF, flush=4'b0001 → in_ready=1, entry dropped, occupancy stays 0.
- Perf counters: out_valid=1, out_ready=0 for 10 cycles → stall_cnt=10 with macro defined, 0 without.
